// File: rtl/hilo_acc_unit.sv
// hilo_acc_unit: Hi/Lo result register for a multiply/divide unit.
// Tracks outstanding operations, applies returned results as load or
// accumulate, accepts direct writes only when nothing is in flight, and
// flags protocol violations with a registered one-cycle err pulse.
module hilo_acc_unit #(
  parameter int W        = 32,
  parameter int MAX_PEND = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           issue,
  output logic           issue_ready,
  input  logic           res_valid,
  input  logic [1:0]     res_op,
  input  logic [2*W-1:0] res_data,
  input  logic           mthi_we,
  input  logic           mtlo_we,
  input  logic [W-1:0]   mt_data,
  output logic [W-1:0]   hi_out,
  output logic [W-1:0]   lo_out,
  output logic           rd_valid,
  output logic           busy,
  output logic           err
);

  localparam int CW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PEND);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  logic [2*W-1:0] hiLo;
  logic [2*W-1:0] hiLoNext;
  logic [CW-1:0]  pendCnt;
  logic [CW-1:0]  pendCntNext;
  logic           errNext;

  logic idle;
  logic issueOk;
  logic issueErr;
  logic resOk;
  logic resSpur;
  logic resRsv;
  logic mtReq;
  logic mtOk;
  logic mtErr;

  // Result application; the reserved op leaves the accumulator untouched.
  // Sums and differences wrap modulo 2^(2W).
  function automatic logic [2*W-1:0] applyResult(
    input logic [1:0]     op,
    input logic [2*W-1:0] acc,
    input logic [2*W-1:0] data
  );
    logic [2*W-1:0] r;
    case (op)
      OP_LOAD: r = data;
      OP_ADD:  r = acc + data;
      OP_SUB:  r = acc - data;
      default: r = acc;
    endcase
    return r;
  endfunction

  assign idle        = (pendCnt == '0);
  assign issue_ready = (pendCnt < MAX_C);
  assign rd_valid    = idle;
  assign busy        = ~idle;
  assign hi_out      = hiLo[2*W-1:W];
  assign lo_out      = hiLo[W-1:0];

  assign issueOk  = issue & issue_ready;
  assign issueErr = issue & ~issue_ready;
  assign resOk    = res_valid & ~idle;
  assign resSpur  = res_valid & idle;
  assign resRsv   = resOk & (res_op == 2'b11);
  assign mtReq    = mthi_we | mtlo_we;
  assign mtOk     = mtReq & idle;
  assign mtErr    = mtReq & ~idle;

  // Next-state: pending count, accumulator contents and violation flag.
  // A result and an accepted direct write are mutually exclusive because
  // one needs pendCnt > 0 and the other pendCnt == 0.
  always_comb begin
    pendCntNext = pendCnt;
    case ({issueOk, resOk})
      2'b10:   pendCntNext = pendCnt + ONE_C;
      2'b01:   pendCntNext = pendCnt - ONE_C;
      default: pendCntNext = pendCnt;
    endcase

    hiLoNext = hiLo;
    if (resOk) begin
      hiLoNext = applyResult(res_op, hiLo, res_data);
    end else if (mtOk) begin
      if (mthi_we) hiLoNext[2*W-1:W] = mt_data;
      if (mtlo_we) hiLoNext[W-1:0]   = mt_data;
    end

    errNext = issueErr | resSpur | resRsv | mtErr;
  end

  // State register; reset clears everything and overrides all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hiLo    <= '0;
      pendCnt <= '0;
      err     <= 1'b0;
    end else begin
      hiLo    <= hiLoNext;
      pendCnt <= pendCntNext;
      err     <= errNext;
    end
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit (W=32, MAX_PEND=4).
module tb_hilo_acc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue;
  logic        issue_ready;
  logic        res_valid;
  logic [1:0]  res_op;
  logic [63:0] res_data;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        rd_valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  hilo_acc_unit #(.W(32), .MAX_PEND(4)) dut (
    .clk(clk), .reset(reset), .issue(issue), .issue_ready(issue_ready),
    .res_valid(res_valid), .res_op(res_op), .res_data(res_data),
    .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
    .hi_out(hi_out), .lo_out(lo_out), .rd_valid(rd_valid), .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idleIn();
    reset = 1'b0; issue = 1'b0; res_valid = 1'b0; res_op = 2'b00;
    res_data = '0; mthi_we = 1'b0; mtlo_we = 1'b0; mt_data = '0;
  endtask

  // One rising edge, then sample on the following falling edge and clear inputs.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    idleIn();
  endtask

  task automatic doRes(input logic [1:0] op, input logic [63:0] d);
    res_valid = 1'b1; res_op = op; res_data = d;
    cyc();
  endtask

  function automatic logic [63:0] hl();
    return {hi_out, lo_out};
  endfunction

  function automatic logic [63:0] pc();
    return 64'(dut.pendCnt);
  endfunction

  initial begin
    idleIn();
    @(negedge clk);

    // Reset state, with an issue present to show reset priority
    reset = 1'b1; issue = 1'b1; res_valid = 1'b1;
    cyc();
    chk("rst_hilo", hl(), 64'h0);
    chk("rst_pend", pc(), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_err", 64'(err), 64'd0);

    // Issue then LOAD
    issue = 1'b1; cyc();
    chk("load_busy_1", 64'(busy), 64'd1);
    chk("load_rdv_0", 64'(rd_valid), 64'd0);
    doRes(2'b00, 64'h0000_0001_FFFF_FFFE);
    chk("load_hilo", hl(), 64'h0000_0001_FFFF_FFFE);
    chk("load_busy_0", 64'(busy), 64'd0);
    chk("load_rdv_1", 64'(rd_valid), 64'd1);
    chk("load_err", 64'(err), 64'd0);

    // Both halves written from one mt_data, then wrap-around accumulate
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hFFFF_FFFF; cyc();
    chk("mt_both", hl(), 64'hFFFF_FFFF_FFFF_FFFF);
    issue = 1'b1; cyc();
    doRes(2'b01, 64'h2);
    chk("add_wrap", hl(), 64'h1);
    issue = 1'b1; cyc();
    doRes(2'b10, 64'h3);
    chk("sub_wrap", hl(), 64'hFFFF_FFFF_FFFF_FFFE);

    // Direct writes while idle
    mthi_we = 1'b1; mt_data = 32'hDEAD_BEEF; cyc();
    chk("mthi_idle", hl(), 64'hDEAD_BEEF_FFFF_FFFE);
    chk("mthi_idle_err", 64'(err), 64'd0);
    mtlo_we = 1'b1; mt_data = 32'h0000_CAFE; cyc();
    chk("mtlo_idle", hl(), 64'hDEAD_BEEF_0000_CAFE);

    // Direct write while busy is rejected
    issue = 1'b1; cyc();
    mthi_we = 1'b1; mt_data = 32'h1234_5678; cyc();
    chk("mthi_busy", hl(), 64'hDEAD_BEEF_0000_CAFE);
    chk("mthi_busy_err", 64'(err), 64'd1);
    cyc();
    chk("err_one_cycle", 64'(err), 64'd0);

    // Reserved op with one pending
    doRes(2'b11, 64'h5);
    chk("rsv_err", 64'(err), 64'd1);
    chk("rsv_pend", pc(), 64'd0);
    chk("rsv_hilo", hl(), 64'hDEAD_BEEF_0000_CAFE);

    // Spurious result
    doRes(2'b00, 64'h55);
    chk("spur_err", 64'(err), 64'd1);
    chk("spur_hilo", hl(), 64'hDEAD_BEEF_0000_CAFE);
    chk("spur_pend", pc(), 64'd0);

    // Fill to MAX_PEND, then overflow
    for (int i = 0; i < 4; i++) begin
      issue = 1'b1; cyc();
    end
    chk("full_ready", 64'(issue_ready), 64'd0);
    chk("full_pend", pc(), 64'd4);
    chk("full_err", 64'(err), 64'd0);
    issue = 1'b1; cyc();
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_pend", pc(), 64'd4);

    // One result frees a slot; simultaneous issue+result keeps the count
    doRes(2'b00, 64'h11);
    chk("drain1_pend", pc(), 64'd3);
    chk("drain1_hilo", hl(), 64'h11);
    issue = 1'b1; doRes(2'b01, 64'h22);
    chk("same_cyc_pend", pc(), 64'd3);
    chk("same_cyc_hilo", hl(), 64'h33);
    chk("same_cyc_err", 64'(err), 64'd0);
    for (int i = 0; i < 3; i++) doRes(2'b01, 64'h1);
    chk("drain_hilo", hl(), 64'h36);
    chk("drain_rdv", 64'(rd_valid), 64'd1);

    // Reset mid-operation
    issue = 1'b1; cyc();
    issue = 1'b1; cyc();
    chk("mid_pend2", pc(), 64'd2);
    reset = 1'b1; cyc();
    chk("mid_rst_pend", pc(), 64'd0);
    chk("mid_rst_hilo", hl(), 64'h0);
    chk("mid_rst_ready", 64'(issue_ready), 64'd1);
    doRes(2'b00, 64'h99);
    chk("post_rst_err", 64'(err), 64'd1);
    chk("post_rst_hilo", hl(), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
